panel_write_scheduler: RTL and testbench
========================================

// Module: panel_write_scheduler
// PURPOSE
//  Sole master of the ledpanel video-memory write port (ctrl_en/ctrl_wr/ctrl_addr/ctrl_wdat).
//  Shares the port between two valid/ready requesters, A (host/network) and B (animation),
//  using round-robin arbitration.
//  Contains a fill engine that sweeps every pixel with one colour (clear or solid fill).
//  Fill holds the port exclusively while it runs. Sits in the ctrl_clk domain, ahead of ledpanel.
// PARAMETERS
//  CHAINED    2   panels in chain; WORDS = CHAINED*4096 valid addresses (0..WORDS-1)
//  OOB_BITS   8   width of saturating out-of-range drop counter
// PORTS
//  ctrl_clk     in   1    sole clock
//  reset        in   1    asynchronous, active-high
//  a_valid      in   1    requester A write pending
//  a_ready      out  1    A accepted this cycle when a_valid&&a_ready
//  a_wr         in   4    A channel enables ([2]=R,[1]=G,[0]=B; [3] passed through)
//  a_addr       in   16   A pixel address {y[5:0], x}
//  a_wdat       in   24   A data [R][G][B]
//  b_valid/b_ready/b_wr/b_addr/b_wdat  same as A, requester B
//  fill_start   in   1    single-cycle pulse: start fill
//  fill_color   in   24   colour sampled on accepted fill_start
//  fill_busy    out  1    fill engine owns the port
//  fill_done    out  1    one-cycle pulse when fill completes
//  ctrl_en      out  1    write strobe to ledpanel
//  ctrl_wr      out  4    channel enables to ledpanel
//  ctrl_addr    out  16   address to ledpanel
//  ctrl_wdat    out  24   data to ledpanel
//  oob_count    out  OOB_BITS  saturating count of dropped out-of-range writes
// BEHAVIOUR
//  Reset values: all outputs 0; state S_ARB; rr_ptr=A; fill address 0; latched colour 0.
//  States:
//  - S_ARB:  serves A/B. fill_start=1 -> S_FILL; no A/B grant that cycle (fill wins ties).
//  - S_FILL: one write per cycle, addresses 0..WORDS-1 ascending, ctrl_wr=4'b0111,
//    ctrl_wdat=latched colour.
//    After the write of WORDS-1 -> S_ARB; fill_done=1 in that first S_ARB cycle only.
//  fill_busy = (state==S_FILL). fill_start is ignored while in S_FILL.
//  a_ready/b_ready are combinational and 0 in S_FILL or when fill_start=1.
//  Arbitration in S_ARB:
//  - Only A valid -> grant A. Only B valid -> grant B.
//  - Both valid -> grant rr_ptr side.
//  - After any grant, rr_ptr = the other side. At most one grant per cycle.
//  - No request -> rr_ptr unchanged.
//  Output timing: ctrl_* registered; accepted request appears on ctrl_* the next cycle
//  (latency 1). Sustained throughput is 1 write/cycle. ctrl_en=0 on idle cycles;
//  ctrl_addr/ctrl_wdat hold their last value.
//  Range check: accepted write with addr >= WORDS is dropped (ready still high, ctrl_en=0).
//  Each drop increments oob_count, which saturates at all-ones.
//  ctrl_wr=0 on an accepted request: still issued with ctrl_en=1 (harmless no-op). No filtering.
//  Fill length is exactly WORDS cycles of ctrl_en=1, starting the cycle after fill_start.
//  Reset mid-fill: abort immediately, all outputs 0, no fill_done.
// STRUCTURE
//  panel_pkg: WORDS(CHAINED) constant, state encoding S_ARB/S_FILL, requester ids REQ_A/REQ_B,
//  FILL_WR=4'b0111.
//  Sub-module rr_arbiter2: 2-way round-robin, inputs req[1:0] + enable, outputs one-hot grant
//  and rr_ptr register.
//  Top holds the FSM, fill counter, output register stage and OOB counter.
// TESTING
//  1. A only: addr 16'h0005, wdat 24'h3F0000, wr 4'b0100 -> next cycle ctrl_en=1 with identical
//     addr/wdat/wr; A then B alone each served.
//  2. A and B both valid 6 cycles from reset -> grants A,B,A,B,A,B; ctrl_en high every cycle.
//  3. fill_start, colour 24'h010203, CHAINED=2 -> 8192 consecutive ctrl_en cycles, addr 0..8191,
//     ctrl_wr=4'b0111; a_ready=0 throughout; fill_done one cycle after the last write.
//  4. fill_start and a_valid in the same cycle -> no A grant; A served right after fill_done.
//  5. A addr 16'h2000 (=WORDS) -> a_ready=1, ctrl_en stays 0, oob_count +1.
//     300 such writes -> oob_count=255.
//  6. Assert reset at fill address 100 -> outputs 0 asynchronously; after release, state S_ARB,
//     new fill restarts at addr 0.

Source files
------------

// File: rtl/panel_pkg.sv
// Shared constants and encodings for the ledpanel write scheduler.
// Covers the FSM states, requester ids, fill channel mask and panel sizing helper.
package panel_pkg;

    typedef enum logic {
        S_ARB  = 1'b0,
        S_FILL = 1'b1
    } panel_state_e;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam logic [3:0] FILL_WR = 4'b0111;

    // One panel is 64 rows by 64 columns of pixels.
    function automatic int unsigned words_of(input int unsigned chained);
        return chained * 32'd4096;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a one-hot grant output.
// rr_ptr names the side that wins the next tie.
module rr_arbiter2
    import panel_pkg::*;
(
    input  logic       ctrl_clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       rr_ptr
);

    // Grant selection: a single requester always wins, ties go to rr_ptr.
    always_comb begin
        grant = 2'b00;
        if (!enable) begin
            grant = 2'b00;
        end else if (req == 2'b11) begin
            grant = (rr_ptr == REQ_B) ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

    // Priority pointer: hand priority to the side that was not just served.
    always_ff @(posedge ctrl_clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= REQ_A;
        end else if (grant[0]) begin
            rr_ptr <= REQ_B;
        end else if (grant[1]) begin
            rr_ptr <= REQ_A;
        end else begin
            rr_ptr <= rr_ptr;
        end
    end

endmodule

// File: rtl/panel_write_scheduler.sv
// Sole master of the ledpanel video-memory write port: arbitrates requesters A/B
// and runs a full-panel fill engine that owns the port while active.
module panel_write_scheduler
    import panel_pkg::*;
#(
    parameter int CHAINED  = 2,
    parameter int OOB_BITS = 8
) (
    input  logic                ctrl_clk,
    input  logic                reset,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [3:0]          a_wr,
    input  logic [15:0]         a_addr,
    input  logic [23:0]         a_wdat,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [3:0]          b_wr,
    input  logic [15:0]         b_addr,
    input  logic [23:0]         b_wdat,
    input  logic                fill_start,
    input  logic [23:0]         fill_color,
    output logic                fill_busy,
    output logic                fill_done,
    output logic                ctrl_en,
    output logic [3:0]          ctrl_wr,
    output logic [15:0]         ctrl_addr,
    output logic [23:0]         ctrl_wdat,
    output logic [OOB_BITS-1:0] oob_count
);

    localparam int unsigned WORDS = words_of(CHAINED);
    localparam logic [16:0] WORDS_C = 17'(WORDS);
    localparam logic [OOB_BITS-1:0] OOB_MAX = {OOB_BITS{1'b1}};
    localparam logic [OOB_BITS-1:0] OOB_ONE = {{(OOB_BITS-1){1'b0}}, 1'b1};

    panel_state_e  state_r, state_s;
    logic [16:0]   fill_cnt_r, fill_cnt_s;
    logic [23:0]   fill_color_r, fill_color_s;
    logic [1:0]    grant_s;
    logic          rr_ptr_s;
    logic          arb_en_s;
    logic          sel_b_s;
    logic [3:0]    req_wr_s;
    logic [15:0]   req_addr_s;
    logic [23:0]   req_wdat_s;
    logic          en_s;
    logic [3:0]    wr_s;
    logic [15:0]   addr_s;
    logic [23:0]   wdat_s;
    logic          done_s;
    logic [OOB_BITS-1:0] oob_s;

    assign arb_en_s  = (state_r == S_ARB) && !fill_start;
    assign a_ready   = grant_s[0];
    assign b_ready   = grant_s[1];
    assign fill_busy = (state_r == S_FILL);

    rr_arbiter2 u_arb (
        .ctrl_clk (ctrl_clk),
        .reset    (reset),
        .req      ({b_valid, a_valid}),
        .enable   (arb_en_s),
        .grant    (grant_s),
        .rr_ptr   (rr_ptr_s)
    );

    // Payload mux: on a tie the winner is whichever side rr_ptr favours.
    always_comb begin
        sel_b_s = 1'b0;
        if (a_valid && b_valid) begin
            sel_b_s = rr_ptr_s;
        end else begin
            sel_b_s = grant_s[1];
        end
        req_wr_s   = sel_b_s ? b_wr   : a_wr;
        req_addr_s = sel_b_s ? b_addr : a_addr;
        req_wdat_s = sel_b_s ? b_wdat : a_wdat;
    end

    // Next-state and next-output logic; the first fill word is issued on the start cycle.
    always_comb begin
        state_s      = state_r;
        fill_cnt_s   = fill_cnt_r;
        fill_color_s = fill_color_r;
        en_s         = 1'b0;
        wr_s         = ctrl_wr;
        addr_s       = ctrl_addr;
        wdat_s       = ctrl_wdat;
        done_s       = 1'b0;
        oob_s        = oob_count;
        case (state_r)
            S_ARB: begin
                if (fill_start) begin
                    state_s      = S_FILL;
                    fill_color_s = fill_color;
                    fill_cnt_s   = 17'd1;
                    en_s         = 1'b1;
                    wr_s         = FILL_WR;
                    addr_s       = 16'd0;
                    wdat_s       = fill_color;
                end else if (grant_s != 2'b00) begin
                    if ({1'b0, req_addr_s} >= WORDS_C) begin
                        oob_s = (oob_count == OOB_MAX) ? oob_count : oob_count + OOB_ONE;
                    end else begin
                        en_s   = 1'b1;
                        wr_s   = req_wr_s;
                        addr_s = req_addr_s;
                        wdat_s = req_wdat_s;
                    end
                end else begin
                    en_s = 1'b0;
                end
            end
            S_FILL: begin
                // Counter reaching WORDS means the last word is already on the port.
                if (fill_cnt_r == WORDS_C) begin
                    state_s = S_ARB;
                    done_s  = 1'b1;
                end else begin
                    en_s       = 1'b1;
                    wr_s       = FILL_WR;
                    addr_s     = fill_cnt_r[15:0];
                    wdat_s     = fill_color_r;
                    fill_cnt_s = fill_cnt_r + 17'd1;
                end
            end
            default: begin
                state_s = S_ARB;
            end
        endcase
    end

    // State, fill engine and registered port outputs.
    always_ff @(posedge ctrl_clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_ARB;
            fill_cnt_r   <= 17'd0;
            fill_color_r <= 24'd0;
            ctrl_en      <= 1'b0;
            ctrl_wr      <= 4'd0;
            ctrl_addr    <= 16'd0;
            ctrl_wdat    <= 24'd0;
            fill_done    <= 1'b0;
            oob_count    <= {OOB_BITS{1'b0}};
        end else begin
            state_r      <= state_s;
            fill_cnt_r   <= fill_cnt_s;
            fill_color_r <= fill_color_s;
            ctrl_en      <= en_s;
            ctrl_wr      <= wr_s;
            ctrl_addr    <= addr_s;
            ctrl_wdat    <= wdat_s;
            fill_done    <= done_s;
            oob_count    <= oob_s;
        end
    end

endmodule

// File: tb/tb_panel_write_scheduler.sv
// Directed self-checking bench for panel_write_scheduler (CHAINED=2, WORDS=8192).
module tb_panel_write_scheduler;

    logic        ctrl_clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, fill_start;
    logic        a_ready, b_ready;
    logic [3:0]  a_wr, b_wr;
    logic [15:0] a_addr, b_addr;
    logic [23:0] a_wdat, b_wdat, fill_color;
    logic        fill_busy, fill_done, ctrl_en;
    logic [3:0]  ctrl_wr;
    logic [15:0] ctrl_addr;
    logic [23:0] ctrl_wdat;
    logic [7:0]  oob_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ctrl_clk = ~ctrl_clk;

    panel_write_scheduler dut (
        .ctrl_clk   (ctrl_clk),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_wr       (a_wr),
        .a_addr     (a_addr),
        .a_wdat     (a_wdat),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_wr       (b_wr),
        .b_addr     (b_addr),
        .b_wdat     (b_wdat),
        .fill_start (fill_start),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .ctrl_en    (ctrl_en),
        .ctrl_wr    (ctrl_wr),
        .ctrl_addr  (ctrl_addr),
        .ctrl_wdat  (ctrl_wdat),
        .oob_count  (oob_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ctrl_clk);
        #1;
    endtask

    initial begin
        int errs;
        logic [15:0] exp_addr;

        reset = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; fill_start = 1'b0;
        a_wr = 4'd0; b_wr = 4'd0; a_addr = 16'd0; b_addr = 16'd0;
        a_wdat = 24'd0; b_wdat = 24'd0; fill_color = 24'd0;
        step(); step();
        check_eq("rst_en",   ctrl_en, 1'b0);
        check_eq("rst_addr", ctrl_addr, 16'd0);
        check_eq("rst_wdat", ctrl_wdat, 24'd0);
        check_eq("rst_wr",   ctrl_wr, 4'd0);
        check_eq("rst_oob",  oob_count, 8'd0);
        check_eq("rst_busy", fill_busy, 1'b0);
        check_eq("rst_done", fill_done, 1'b0);
        reset = 1'b0;
        step();

        // A alone, then B alone
        a_valid = 1'b1; a_addr = 16'h0005; a_wdat = 24'h3F0000; a_wr = 4'b0100;
        #1;
        check_eq("a_only_ready", a_ready, 1'b1);
        step();
        a_valid = 1'b0;
        check_eq("a_only_en",   ctrl_en, 1'b1);
        check_eq("a_only_addr", ctrl_addr, 16'h0005);
        check_eq("a_only_wdat", ctrl_wdat, 24'h3F0000);
        check_eq("a_only_wr",   ctrl_wr, 4'b0100);
        b_valid = 1'b1; b_addr = 16'h0007; b_wdat = 24'h00FF00; b_wr = 4'b0010;
        #1;
        check_eq("b_only_ready", b_ready, 1'b1);
        check_eq("b_only_a_rdy", a_ready, 1'b0);
        step();
        b_valid = 1'b0;
        check_eq("b_only_en",   ctrl_en, 1'b1);
        check_eq("b_only_addr", ctrl_addr, 16'h0007);
        check_eq("b_only_wdat", ctrl_wdat, 24'h00FF00);
        check_eq("b_only_wr",   ctrl_wr, 4'b0010);
        step();
        check_eq("idle_en",   ctrl_en, 1'b0);
        check_eq("idle_hold", ctrl_addr, 16'h0007);

        // Both valid straight from reset: A,B,A,B,A,B
        reset = 1'b1; #1; reset = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            a_valid = 1'b1; b_valid = 1'b1;
            a_addr = 16'h0100 + 16'(i); b_addr = 16'h0200 + 16'(i);
            a_wdat = 24'hA00000 + 24'(i); b_wdat = 24'hB00000 + 24'(i);
            a_wr = 4'b0111; b_wr = 4'b0111;
            #1;
            check_eq($sformatf("rr_a_ready%0d", i), a_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
            check_eq($sformatf("rr_b_ready%0d", i), b_ready, (i % 2 == 1) ? 1'b1 : 1'b0);
            step();
            check_eq($sformatf("rr_en%0d", i), ctrl_en, 1'b1);
            check_eq($sformatf("rr_addr%0d", i), ctrl_addr,
                     (i % 2 == 0) ? 16'h0100 + 16'(i) : 16'h0200 + 16'(i));
        end
        b_valid = 1'b0;

        // Fill with A colliding on the start cycle
        a_valid = 1'b1; a_addr = 16'h0042; a_wdat = 24'hABCDEF; a_wr = 4'b0111;
        fill_start = 1'b1; fill_color = 24'h010203;
        #1;
        check_eq("fill_tie_a_ready", a_ready, 1'b0);
        check_eq("fill_tie_b_ready", b_ready, 1'b0);
        step();
        fill_start = 1'b0; fill_color = 24'h000000;
        errs = 0;
        for (int k = 0; k < 8192; k++) begin
            exp_addr = 16'(k);
            if (ctrl_en !== 1'b1 || ctrl_addr !== exp_addr || ctrl_wr !== 4'b0111 ||
                ctrl_wdat !== 24'h010203 || a_ready !== 1'b0 || fill_busy !== 1'b1 ||
                fill_done !== 1'b0) begin
                errs++;
            end
            if (k == 0)    check_eq("fill_first_addr", ctrl_addr, 16'd0);
            if (k == 8191) check_eq("fill_last_addr", ctrl_addr, 16'd8191);
            if (k != 8191) step();
        end
        check_eq("fill_seq_errs", errs, 0);
        step();
        check_eq("fill_end_en",   ctrl_en, 1'b0);
        check_eq("fill_done",     fill_done, 1'b1);
        check_eq("fill_end_busy", fill_busy, 1'b0);
        check_eq("post_fill_a_ready", a_ready, 1'b1);
        step();
        a_valid = 1'b0;
        check_eq("post_fill_a_en",   ctrl_en, 1'b1);
        check_eq("post_fill_a_addr", ctrl_addr, 16'h0042);
        check_eq("post_fill_a_wdat", ctrl_wdat, 24'hABCDEF);
        check_eq("done_one_cycle",   fill_done, 1'b0);

        // Range boundary and out-of-range drops
        a_valid = 1'b1; a_addr = 16'h1FFF; a_wdat = 24'h112233; a_wr = 4'b0001;
        step();
        check_eq("last_valid_en",   ctrl_en, 1'b1);
        check_eq("last_valid_addr", ctrl_addr, 16'h1FFF);
        a_addr = 16'h2000; a_wdat = 24'h445566;
        #1;
        check_eq("oob_ready", a_ready, 1'b1);
        step();
        check_eq("oob_en",   ctrl_en, 1'b0);
        check_eq("oob_hold", ctrl_addr, 16'h1FFF);
        check_eq("oob_one",  oob_count, 8'd1);
        errs = 0;
        for (int k = 1; k < 300; k++) begin
            step();
            if (ctrl_en !== 1'b0) errs++;
        end
        check_eq("oob_no_strobe", errs, 0);
        check_eq("oob_saturate", oob_count, 8'd255);
        a_valid = 1'b0;

        // Reset in the middle of a fill
        fill_start = 1'b1; fill_color = 24'h0A0B0C;
        step();
        fill_start = 1'b0;
        for (int k = 0; k < 100; k++) step();
        check_eq("mid_fill_addr", ctrl_addr, 16'd100);
        reset = 1'b1;
        #1;
        check_eq("abort_en",   ctrl_en, 1'b0);
        check_eq("abort_addr", ctrl_addr, 16'd0);
        check_eq("abort_wdat", ctrl_wdat, 24'd0);
        check_eq("abort_wr",   ctrl_wr, 4'd0);
        check_eq("abort_busy", fill_busy, 1'b0);
        check_eq("abort_oob",  oob_count, 8'd0);
        step();
        reset = 1'b0;
        errs = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (fill_done !== 1'b0 || ctrl_en !== 1'b0 || fill_busy !== 1'b0) errs++;
        end
        check_eq("abort_quiet", errs, 0);
        fill_start = 1'b1; fill_color = 24'hFFFFFF;
        step();
        fill_start = 1'b0;
        check_eq("restart_en",   ctrl_en, 1'b1);
        check_eq("restart_addr", ctrl_addr, 16'd0);
        check_eq("restart_wdat", ctrl_wdat, 24'hFFFFFF);
        step();
        check_eq("restart_addr1", ctrl_addr, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
